// File: rtl/mem_arb_if.sv
// Request/response bundle between the IFU, LSU, memory side and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_arb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MASK_W = 4
);
   logic              ifu_req_valid;
   logic              ifu_req_ready;
   logic [ADDR_W-1:0] ifu_addr;
   logic              ifu_resp_valid;
   logic [DATA_W-1:0] ifu_rdata;

   logic              lsu_req_valid;
   logic              lsu_req_ready;
   logic [ADDR_W-1:0] lsu_addr;
   logic              lsu_wen;
   logic [DATA_W-1:0] lsu_wdata;
   logic [MASK_W-1:0] lsu_wmask;
   logic              lsu_resp_valid;
   logic [DATA_W-1:0] lsu_rdata;

   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wen;
   logic [DATA_W-1:0] mem_wdata;
   logic [MASK_W-1:0] mem_wmask;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  ifu_req_valid, ifu_addr,
      output ifu_req_ready, ifu_resp_valid, ifu_rdata,
      input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      output lsu_req_ready, lsu_resp_valid, lsu_rdata,
      output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      input  mem_req_ready, mem_resp_valid, mem_rdata
   );

   modport master (
      output ifu_req_valid, ifu_addr,
      input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
      output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
      input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      output mem_req_ready, mem_resp_valid, mem_rdata
   );
endinterface

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, one transaction in flight.
// Handshake: a request transfers on a cycle where valid && ready; responses are one-cycle pulses.
module mem_arb #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MASK_W = 4
) (
   input  logic       clk,
   input  logic       rst,
   mem_arb_if.slave   bus,
   output logic [1:0] o_state
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic SRC_IFU = 1'b0;
   localparam logic SRC_LSU = 1'b1;

   state_t            r_state;
   state_t            w_next;
   logic              r_owner;
   logic              r_last;
   logic [ADDR_W-1:0] r_addr;
   logic              r_wen;
   logic [DATA_W-1:0] r_wdata;
   logic [MASK_W-1:0] r_wmask;
   logic [DATA_W-1:0] r_ifu_rdata;
   logic [DATA_W-1:0] r_lsu_rdata;

   logic w_any;
   logic w_pick_lsu;
   logic w_accept;

   // With both sources valid, the one that did not win last time goes first.
   always_comb begin
      w_any = bus.ifu_req_valid | bus.lsu_req_valid;
      if (bus.ifu_req_valid && bus.lsu_req_valid) w_pick_lsu = (r_last == SRC_IFU);
      else                                         w_pick_lsu = bus.lsu_req_valid;
      w_accept = (r_state == S_IDLE) && w_any;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)          w_next = S_REQ;
         S_REQ:   if (bus.mem_req_ready)  w_next = S_RESP;
         S_RESP:  if (bus.mem_resp_valid) w_next = S_DONE;
         S_DONE:                          w_next = S_IDLE;
         default:                         w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_owner     <= SRC_IFU;
         r_last      <= SRC_LSU;
         r_addr      <= '0;
         r_wen       <= 1'b0;
         r_wdata     <= '0;
         r_wmask     <= '0;
         r_ifu_rdata <= '0;
         r_lsu_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_owner <= w_pick_lsu;
            r_last  <= w_pick_lsu;
            r_addr  <= w_pick_lsu ? bus.lsu_addr : bus.ifu_addr;
            r_wen   <= w_pick_lsu & bus.lsu_wen;
            r_wdata <= w_pick_lsu ? bus.lsu_wdata : '0;
            r_wmask <= (w_pick_lsu && bus.lsu_wen) ? bus.lsu_wmask : '0;
         end
         // Captured on the RESP->DONE edge so the new value first appears with the pulse.
         if (r_state == S_RESP && bus.mem_resp_valid) begin
            if (r_owner == SRC_LSU) r_lsu_rdata <= r_wen ? '0 : bus.mem_rdata;
            else                    r_ifu_rdata <= bus.mem_rdata;
         end
      end
   end

   always_comb begin
      bus.ifu_req_ready  = rst && w_accept && !w_pick_lsu;
      bus.lsu_req_ready  = rst && w_accept && w_pick_lsu;
      bus.mem_req_valid  = (r_state == S_REQ);
      bus.mem_addr       = r_addr;
      bus.mem_wen        = r_wen;
      bus.mem_wdata      = r_wdata;
      bus.mem_wmask      = r_wmask;
      bus.ifu_resp_valid = (r_state == S_DONE) && (r_owner == SRC_IFU);
      bus.lsu_resp_valid = (r_state == S_DONE) && (r_owner == SRC_LSU);
      bus.ifu_rdata      = r_ifu_rdata;
      bus.lsu_rdata      = r_lsu_rdata;
      o_state            = r_state;
   end
endmodule
